// File: rtl/nucleo_ula_multiciclo.sv
// Multi-cycle ALU core: register file, IDLE/READ/EXEC/WRITE sequencing,
// command handshake and a WIDTH-cycle shift-add multiplier.
module nucleo_ula_multiciclo #(
    parameter  int unsigned WIDTH  = 8,
    parameter  int unsigned NREGS  = 4,
    localparam int unsigned REG_AW = $clog2(NREGS)
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [3:0]        cmd_op_i,
    input  logic [REG_AW-1:0] cmd_dst_i,
    input  logic [REG_AW-1:0] cmd_src_a_i,
    input  logic [REG_AW-1:0] cmd_src_b_i,
    input  logic [WIDTH-1:0]  cmd_imm_i,
    output logic              res_valid_o,
    output logic [WIDTH-1:0]  res_data_o,
    output logic              res_err_o,
    output logic              flag_z_o,
    output logic              flag_c_o,
    output logic              flag_v_o,
    output logic              busy_o,
    input  logic [REG_AW-1:0] dbg_sel_i,
    output logic [WIDTH-1:0]  dbg_data_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_EXEC  = 2'd2;
    localparam logic [1:0] S_WRITE = 2'd3;

    localparam logic [3:0] OP_LDI = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_NOT = 4'd6;
    localparam logic [3:0] OP_SHL = 4'd7;
    localparam logic [3:0] OP_SHR = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;
    localparam logic [3:0] OP_MOV = 4'd10;

    logic [1:0]           state_q,  state_d;
    logic                 ready_q,  ready_d;
    logic [3:0]           op_q,     op_d;
    logic [REG_AW-1:0]    dst_q,    dst_d;
    logic [REG_AW-1:0]    sa_q,     sa_d;
    logic [REG_AW-1:0]    sb_q,     sb_d;
    logic [WIDTH-1:0]     imm_q,    imm_d;
    logic [WIDTH-1:0]     a_q,      a_d;
    logic [WIDTH-1:0]     b_q,      b_d;
    logic [2*WIDTH-1:0]   acc_q,    acc_d;
    logic [2*WIDTH-1:0]   mcand_q,  mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CNT_W-1:0]     cnt_q,    cnt_d;
    logic [WIDTH-1:0]     ex_res_q, ex_res_d;
    logic                 ex_c_q,   ex_c_d;
    logic                 ex_v_q,   ex_v_d;
    logic [WIDTH-1:0]     rf_q [NREGS];
    logic [WIDTH-1:0]     rf_d [NREGS];
    logic [WIDTH-1:0]     res_data_q, res_data_d;
    logic                 res_valid_q, res_valid_d;
    logic                 res_err_q,  res_err_d;
    logic                 z_q, z_d, c_q, c_d, v_q, v_d;

    logic [WIDTH:0]       sum_c;
    logic [WIDTH:0]       diff_c;
    logic [2*WIDTH-1:0]   acc_step_c;
    logic                 illegal_c;

    assign sum_c      = {1'b0, a_q} + {1'b0, b_q};
    assign diff_c     = {1'b0, a_q} - {1'b0, b_q};
    assign acc_step_c = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign illegal_c  = (op_q > OP_MOV);

    // Next-state sequencing; MUL holds EXEC for WIDTH cycles
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (cmd_valid_i) state_d = S_READ;
            S_READ:  state_d = S_EXEC;
            S_EXEC:  if ((op_q != OP_MUL) || (cnt_q == CNT_W'(WIDTH - 1))) state_d = S_WRITE;
            S_WRITE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: capture, operand read, execute, write-back
    always_comb begin
        ready_d     = (state_d == S_IDLE);
        op_d        = op_q;
        dst_d       = dst_q;
        sa_d        = sa_q;
        sb_d        = sb_q;
        imm_d       = imm_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        cnt_d       = cnt_q;
        ex_res_d    = ex_res_q;
        ex_c_d      = ex_c_q;
        ex_v_d      = ex_v_q;
        rf_d        = rf_q;
        res_data_d  = res_data_q;
        res_valid_d = 1'b0;
        res_err_d   = 1'b0;
        z_d         = z_q;
        c_d         = c_q;
        v_d         = v_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    op_d  = cmd_op_i;
                    dst_d = cmd_dst_i;
                    sa_d  = cmd_src_a_i;
                    sb_d  = cmd_src_b_i;
                    imm_d = cmd_imm_i;
                end
            end
            S_READ: begin
                a_d      = rf_q[sa_q];
                b_d      = rf_q[sb_q];
                acc_d    = '0;
                mcand_d  = {{WIDTH{1'b0}}, rf_q[sa_q]};
                mplier_d = rf_q[sb_q];
                cnt_d    = '0;
            end
            S_EXEC: begin
                ex_res_d = '0;
                ex_c_d   = 1'b0;
                ex_v_d   = 1'b0;
                case (op_q)
                    OP_LDI: ex_res_d = imm_q;
                    OP_ADD: begin
                        ex_res_d = sum_c[WIDTH-1:0];
                        ex_c_d   = sum_c[WIDTH];
                        ex_v_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                   (sum_c[WIDTH-1] != a_q[WIDTH-1]);
                    end
                    OP_SUB: begin
                        ex_res_d = diff_c[WIDTH-1:0];
                        ex_c_d   = diff_c[WIDTH];
                        ex_v_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                                   (diff_c[WIDTH-1] != a_q[WIDTH-1]);
                    end
                    OP_AND: ex_res_d = a_q & b_q;
                    OP_OR:  ex_res_d = a_q | b_q;
                    OP_XOR: ex_res_d = a_q ^ b_q;
                    OP_NOT: ex_res_d = ~a_q;
                    OP_SHL: begin
                        ex_res_d = {a_q[WIDTH-2:0], 1'b0};
                        ex_c_d   = a_q[WIDTH-1];
                    end
                    OP_SHR: begin
                        ex_res_d = {1'b0, a_q[WIDTH-1:1]};
                        ex_c_d   = a_q[0];
                    end
                    OP_MUL: begin
                        acc_d    = acc_step_c;
                        mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
                        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                        cnt_d    = cnt_q + CNT_W'(1);
                        ex_res_d = acc_step_c[WIDTH-1:0];
                        ex_c_d   = |acc_step_c[2*WIDTH-1:WIDTH];
                    end
                    OP_MOV: ex_res_d = a_q;
                    default: ex_res_d = '0;
                endcase
            end
            S_WRITE: begin
                res_valid_d = 1'b1;
                if (illegal_c) begin
                    res_err_d = 1'b1;
                end else begin
                    rf_d[dst_q] = ex_res_q;
                    res_data_d  = ex_res_q;
                    if (op_q != OP_LDI) begin
                        z_d = (ex_res_q == '0);
                        c_d = ex_c_q;
                        v_d = ex_v_q;
                    end
                end
            end
            default: ;
        endcase
    end

    // State and datapath registers; reset aborts any command in flight
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b1;
            op_q        <= '0;
            dst_q       <= '0;
            sa_q        <= '0;
            sb_q        <= '0;
            imm_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
            ex_res_q    <= '0;
            ex_c_q      <= 1'b0;
            ex_v_q      <= 1'b0;
            for (int i = 0; i < int'(NREGS); i++) rf_q[i] <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            res_err_q   <= 1'b0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            op_q        <= op_d;
            dst_q       <= dst_d;
            sa_q        <= sa_d;
            sb_q        <= sb_d;
            imm_q       <= imm_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            cnt_q       <= cnt_d;
            ex_res_q    <= ex_res_d;
            ex_c_q      <= ex_c_d;
            ex_v_q      <= ex_v_d;
            rf_q        <= rf_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
            res_err_q   <= res_err_d;
            z_q         <= z_d;
            c_q         <= c_d;
            v_q         <= v_d;
        end
    end

    assign cmd_ready_o = ready_q;
    assign busy_o      = ~ready_q;
    assign res_valid_o = res_valid_q;
    assign res_err_o   = res_err_q;
    assign res_data_o  = res_data_q;
    assign flag_z_o    = z_q;
    assign flag_c_o    = c_q;
    assign flag_v_o    = v_q;
    assign dbg_data_o  = rf_q[dbg_sel_i];

endmodule

// File: tb/tb_nucleo_ula_multiciclo.sv
// Bench for nucleo_ula_multiciclo (WIDTH=8, NREGS=4): directed commands,
// a per-cycle comparison against an arithmetic reference model, and
// hand-computed literal expectations.
module tb_nucleo_ula_multiciclo;

    localparam int W  = 8;
    localparam int NR = 4;

    logic       clock;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [1:0] cmd_dst, cmd_src_a, cmd_src_b;
    logic [7:0] cmd_imm;
    logic       res_valid;
    logic [7:0] res_data;
    logic       res_err;
    logic       flag_z, flag_c, flag_v, busy;
    logic [1:0] dbg_sel;
    logic [7:0] dbg_data;

    nucleo_ula_multiciclo #(.WIDTH(W), .NREGS(NR)) dut (
        .clock_i     (clock),
        .reset_i     (reset),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_op_i    (cmd_op),
        .cmd_dst_i   (cmd_dst),
        .cmd_src_a_i (cmd_src_a),
        .cmd_src_b_i (cmd_src_b),
        .cmd_imm_i   (cmd_imm),
        .res_valid_o (res_valid),
        .res_data_o  (res_data),
        .res_err_o   (res_err),
        .flag_z_o    (flag_z),
        .flag_c_o    (flag_c),
        .flag_v_o    (flag_v),
        .busy_o      (busy),
        .dbg_sel_i   (dbg_sel),
        .dbg_data_o  (dbg_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int dbg_pick = -1;

    always @(posedge clock) cyc <= cyc + 1;

    // reference model state (committed results) and the one command in flight
    int m_rf [NR];
    int m_data;
    bit m_z, m_c, m_v;
    bit p_act = 0;
    int p_edge, p_res, p_dst;
    bit p_c, p_v, p_err, p_fl;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int sgn(input int x);
        return (x >= 128) ? x - 256 : x;
    endfunction

    // what a command must produce, from the opcode table with plain integers
    function automatic void model_op(input int op, input int a, input int b, input int imm,
                                     output int res, output bit c, output bit v,
                                     output bit err, output bit fl);
        int s;
        res = 0; c = 0; v = 0; err = 0; fl = 1;
        case (op)
            0:  begin res = imm; fl = 0; end
            1:  begin res = (a + b) % 256; c = (a + b) > 255;
                      s = sgn(a) + sgn(b); v = (s > 127) || (s < -128); end
            2:  begin res = (a - b + 256) % 256; c = a < b;
                      s = sgn(a) - sgn(b); v = (s > 127) || (s < -128); end
            3:  res = a & b;
            4:  res = a | b;
            5:  res = a ^ b;
            6:  res = 255 - a;
            7:  begin res = (a * 2) % 256; c = a >= 128; end
            8:  begin res = a / 2; c = (a % 2) == 1; end
            9:  begin res = (a * b) % 256; c = (a * b) > 255; end
            10: res = a;
            default: begin err = 1; fl = 0; end
        endcase
    endfunction

    // every-cycle comparison of all outputs against the model
    always @(negedge clock) begin : cmp
        bit ev, ee;
        int lat;
        ev = 0; ee = 0;
        if (reset) begin
            for (int i = 0; i < NR; i++) m_rf[i] = 0;
            m_data = 0; m_z = 0; m_c = 0; m_v = 0;
            p_act = 0;
        end else if (p_act && cyc == p_edge) begin
            ev = 1; ee = p_err; p_act = 0;
            if (!p_err) begin
                m_rf[p_dst] = p_res;
                m_data = p_res;
                if (p_fl) begin m_z = (p_res == 0); m_c = p_c; m_v = p_v; end
            end
        end
        dbg_sel = (dbg_pick >= 0) ? 2'(dbg_pick) : 2'(cyc);
        #1;
        chk("res_valid", 32'(res_valid), 32'(ev));
        chk("res_err",   32'(res_err),   32'(ee));
        chk("res_data",  32'(res_data),  32'(m_data));
        chk("flag_z",    32'(flag_z),    32'(m_z));
        chk("flag_c",    32'(flag_c),    32'(m_c));
        chk("flag_v",    32'(flag_v),    32'(m_v));
        chk("cmd_ready", 32'(cmd_ready), 32'(!p_act));
        chk("busy",      32'(busy),      32'(p_act));
        chk("dbg_data",  32'(dbg_data),  32'(m_rf[dbg_sel]));
        if (!reset && !p_act && cmd_valid) begin
            model_op(int'(cmd_op), m_rf[cmd_src_a], m_rf[cmd_src_b], int'(cmd_imm),
                     p_res, p_c, p_v, p_err, p_fl);
            p_dst = int'(cmd_dst);
            lat = (cmd_op == 4'd9) ? W + 2 : 3;
            p_edge = cyc + 1 + lat;
            p_act = 1;
        end
    end

    task automatic align();
        @(posedge clock); #2;
    endtask

    task automatic issue(input int op, input int dst, input int a, input int b,
                         input int imm, output int acc_edge);
        cmd_valid = 1'b1;
        cmd_op = op[3:0]; cmd_dst = dst[1:0]; cmd_src_a = a[1:0]; cmd_src_b = b[1:0];
        cmd_imm = imm[7:0];
        acc_edge = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock); #3;
            if (cmd_ready) begin
                @(posedge clock); #2;
                acc_edge = cyc;
                break;
            end
        end
        cmd_valid = 1'b0;
        if (acc_edge < 0) chk("accept_timeout", 0, 1);
    endtask

    // issue, wait for completion, check latency and busy duration;
    // returns sampled in the res_valid cycle
    task automatic run(input int op, input int dst, input int a, input int b,
                       input int imm, input int exp_lat);
        int acc, done, busy_n;
        issue(op, dst, a, b, imm, acc);
        done = -1; busy_n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock); #3;
            if (res_valid) begin done = cyc; break; end
            if (busy) busy_n++;
        end
        if (done < 0) chk("done_timeout", 0, 1);
        else begin
            chk("latency", 32'(done - acc), 32'(exp_lat));
            chk("busy_cycles", 32'(busy_n), 32'(exp_lat));
        end
    endtask

    task automatic read_reg(input int idx, input int exp, input string name);
        dbg_pick = idx;
        @(negedge clock); #3;
        chk(name, 32'(dbg_data), 32'(exp));
        dbg_pick = -1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int acc1, acc2, p1, p2, pulses, d2;
        bit drop;
        reset = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_dst = '0;
        cmd_src_a = '0; cmd_src_b = '0; cmd_imm = '0;
        #1 reset = 1'b1;
        repeat (3) @(posedge clock);
        #2 reset = 1'b0;
        chk("rst_ready", 32'(cmd_ready), 1);
        chk("rst_data",  32'(res_data), 0);
        chk("rst_valid", 32'(res_valid), 0);

        // 1: load and signed-overflowing add
        run(0, 1, 0, 0, 8'h7F, 3); align();
        run(0, 2, 0, 0, 8'h01, 3); align();
        run(1, 3, 1, 2, 0, 3);
        chk("add_data", 32'(res_data), 32'h80);
        chk("add_zcv", {29'd0, flag_z, flag_c, flag_v}, 32'b001);
        read_reg(3, 8'h80, "add_r3");
        align();

        // 2: sub with borrow, shifts
        run(2, 0, 2, 1, 0, 3);
        chk("sub_data", 32'(res_data), 32'h82);
        chk("sub_zcv", {29'd0, flag_z, flag_c, flag_v}, 32'b010);
        align();
        run(7, 0, 1, 0, 0, 3);
        chk("shl_data", 32'(res_data), 32'hFE);
        chk("shl_c", 32'(flag_c), 0);
        align();
        run(8, 2, 2, 0, 0, 3);
        chk("shr_data", 32'(res_data), 32'h00);
        chk("shr_zc", {30'd0, flag_z, flag_c}, 32'b11);
        align();

        // 3: multiply with non-zero upper half
        run(0, 1, 0, 0, 8'h10, 3); align();
        run(0, 2, 0, 0, 8'h20, 3); align();
        run(9, 3, 1, 2, 0, W + 2);
        chk("mul_data", 32'(res_data), 32'h00);
        chk("mul_zc", {30'd0, flag_z, flag_c}, 32'b11);
        align();

        // 4: second command held valid while busy
        issue(1, 0, 1, 2, 0, acc1);
        cmd_valid = 1'b1; cmd_op = 4'd5; cmd_dst = 2'd1; cmd_src_a = 2'd1; cmd_src_b = 2'd2;
        pulses = 0; p1 = -1; p2 = -1; acc2 = -1; drop = 0; d2 = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock); #3;
            if (drop) begin cmd_valid = 1'b0; drop = 0; end
            if (res_valid) begin
                pulses++;
                if (p1 < 0) p1 = cyc; else begin p2 = cyc; d2 = int'(res_data); end
            end
            if (cmd_valid && cmd_ready) begin acc2 = cyc + 1; drop = 1; end
        end
        cmd_valid = 1'b0;
        chk("b2b_pulses", 32'(pulses), 2);
        chk("b2b_first_lat", 32'(p1 - acc1), 3);
        chk("b2b_accept", 32'(acc2 - p1), 1);
        chk("b2b_second_lat", 32'(p2 - acc2), 3);
        chk("b2b_xor_data", 32'(d2), 32'h30);
        align();

        // 5: reset in the middle of a multiply
        issue(9, 3, 1, 2, 0, acc1);
        repeat (4) @(posedge clock);
        #2 reset = 1'b1;
        @(negedge clock); #3;
        chk("abort_data", 32'(res_data), 0);
        chk("abort_flags", {29'd0, flag_z, flag_c, flag_v}, 0);
        chk("abort_ready", 32'(cmd_ready), 1);
        align(); align();
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clock); #3;
            if (res_valid) pulses++;
        end
        chk("abort_no_valid", 32'(pulses), 0);
        chk("abort_ready_after", 32'(cmd_ready), 1);
        read_reg(3, 0, "abort_r3");
        align();

        // 6: illegal opcode keeps state; plus NOT/MOV/illegal 11
        run(3, 0, 0, 0, 0, 3);
        chk("and_z", 32'(flag_z), 1);
        align();
        run(0, 1, 0, 0, 8'h55, 3);
        chk("ldi_keeps_z", 32'(flag_z), 1);
        align();
        run(15, 1, 1, 1, 8'hFF, 3);
        chk("ill_err", 32'(res_err), 1);
        chk("ill_data", 32'(res_data), 32'h55);
        chk("ill_z", 32'(flag_z), 1);
        read_reg(1, 8'h55, "ill_r1");
        align();
        run(6, 2, 1, 0, 0, 3);
        chk("not_data", 32'(res_data), 32'hAA);
        align();
        run(10, 3, 2, 0, 0, 3);
        chk("mov_data", 32'(res_data), 32'hAA);
        align();
        run(11, 0, 0, 0, 0, 3);
        chk("ill11_err", 32'(res_err), 1);
        read_reg(0, 0, "ill11_r0");
        align();
        run(1, 2, 2, 3, 0, 3);
        chk("add_carry_data", 32'(res_data), 32'h54);
        chk("add_carry_zcv", {29'd0, flag_z, flag_c, flag_v}, 32'b011);
        align();
        repeat (3) @(posedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
